// File: rtl/ecg_pkg.sv
// ecg_pkg: shared sample type, deframer state encoding and default sync byte.
// ECG_DEFRAME_CHECKSUM_EN adds the GET_CHK state and the checksum helper.
package ecg_pkg;
    typedef logic signed [15:0] sample_t;
`ifdef ECG_DEFRAME_CHECKSUM_EN
    typedef enum logic [1:0] {HUNT, GET_HI, GET_LO, GET_CHK} state_t;
    function automatic logic [7:0] frame_chk(input logic [7:0] hi, input logic [7:0] lo);
        return hi ^ lo;
    endfunction
`else
    typedef enum logic [1:0] {HUNT, GET_HI, GET_LO} state_t;
`endif
    localparam logic [7:0] ECG_SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/ecg_deframer_byte_gap_timer.sv
// byte_gap_timer: counts idle cycles between bytes; pulses tc at TIMEOUT_CYCLES-1.
module byte_gap_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic Clk,
    input  logic nRst,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int W = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [W-1:0] count;
    // a byte in the terminal cycle wins, so clear masks the pulse
    assign tc = enable && !clear && count == W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !tc)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/ecg_deframer.sv
// ecg_deframer: UART byte stream -> big-endian signed 16-bit ECG samples with timeout recovery.
// ECG_DEFRAME_CHECKSUM_EN selects 4-byte frames with an HI^LO check byte.
module ecg_deframer
    import ecg_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = ECG_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       nRst,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output sample_t    sample,
    output logic       sample_valid,
    output logic       frame_err,
    output logic [7:0] err_count
);
    state_t     state, state_nxt;
    logic [7:0] hi;
    logic       load, err, tc;
    sample_t    sample_nxt;
`ifdef ECG_DEFRAME_CHECKSUM_EN
    logic [7:0] lo;
`endif

    byte_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .Clk   (Clk),
        .nRst  (nRst),
        .clear (rx_ready || state == HUNT),
        .enable(state != HUNT),
        .tc    (tc)
    );

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        err        = 1'b0;
        sample_nxt = {hi, rx_data};
        case (state)
            HUNT:   if (rx_ready && rx_data == SYNC_BYTE) state_nxt = GET_HI;
            GET_HI: if (rx_ready) state_nxt = GET_LO;
`ifdef ECG_DEFRAME_CHECKSUM_EN
            GET_LO: if (rx_ready) state_nxt = GET_CHK;
            GET_CHK: begin
                sample_nxt = {hi, lo};
                if (rx_ready) begin
                    load      = rx_data == frame_chk(hi, lo);
                    err       = !load;
                    state_nxt = HUNT;
                end
            end
`else
            GET_LO: begin
                load      = rx_ready;
                state_nxt = rx_ready ? HUNT : state;
            end
`endif
            default: state_nxt = HUNT;
        endcase
        if (tc) begin
            err       = 1'b1;
            state_nxt = HUNT;
        end
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state        <= HUNT;
            hi           <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            err_count    <= '0;
        end else begin
            state        <= state_nxt;
            hi           <= (state == GET_HI && rx_ready) ? rx_data : hi;
            sample       <= load ? sample_nxt : sample;
            sample_valid <= load;
            frame_err    <= err;
            err_count    <= (err && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
        end
    end

`ifdef ECG_DEFRAME_CHECKSUM_EN
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst)
            lo <= '0;
        else if (state == GET_LO && rx_ready)
            lo <= rx_data;
    end
`endif
endmodule

// File: tb/tb_ecg_deframer.sv
// tb_ecg_deframer: random and directed byte streams checked every cycle against a frame-level model.
module tb_ecg_deframer;
    localparam int T = 20;
`ifdef ECG_DEFRAME_CHECKSUM_EN
    localparam int FLEN = 4;
`else
    localparam int FLEN = 3;
`endif
    logic        Clk = 0, nRst = 0, rx_ready = 0;
    logic [7:0]  rx_data = 0;
    logic [15:0] sample;
    logic        sample_valid, frame_err;
    logic [7:0]  err_count;
    int n_cmp = 0, n_bad = 0;
    logic [7:0]  fb [4];
    int          nfr = 0, gap = 0;
    logic [15:0] m_sample = 0;
    logic        m_valid = 0, m_err = 0;
    int          m_cnt = 0;

    ecg_deframer #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T)) dut (
        .Clk(Clk), .nRst(nRst), .rx_data(rx_data), .rx_ready(rx_ready),
        .sample(sample), .sample_valid(sample_valid), .frame_err(frame_err), .err_count(err_count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".sample"}, {16'h0, sample}, {16'h0, m_sample});
        chk({where, ".valid"}, {31'h0, sample_valid}, {31'h0, m_valid});
        chk({where, ".err"}, {31'h0, frame_err}, {31'h0, m_err});
        chk({where, ".cnt"}, {24'h0, err_count}, m_cnt);
    endtask

    function automatic void model_reset();
        nfr = 0; gap = 0; m_sample = 0; m_valid = 0; m_err = 0; m_cnt = 0;
    endfunction

    // frame-level reference: a frame is sync plus FLEN-1 bytes, each within T cycles of the last
    function automatic void model_step(input logic rdy, input logic [7:0] d);
        m_valid = 0; m_err = 0;
        if (nfr == 0) begin
            if (rdy && d == 8'hA5) begin nfr = 1; gap = 0; end
        end else if (rdy) begin
            fb[nfr] = d; nfr++; gap = 0;
            if (nfr == FLEN) begin
                if (FLEN == 3 || fb[3] == (fb[1] ^ fb[2])) begin
                    m_sample = {fb[1], fb[2]}; m_valid = 1;
                end else m_err = 1;
                nfr = 0;
            end
        end else begin
            gap++;
            if (gap >= T) begin m_err = 1; nfr = 0; end
        end
        if (m_err && m_cnt < 255) m_cnt++;
    endfunction

    task automatic cyc(input logic rdy, input logic [7:0] d, input string where);
        rx_ready = rdy; rx_data = d;
        @(posedge Clk);
        model_step(rdy, d);
        #1;
        check_all(where);
    endtask

    task automatic send(input logic [7:0] d, input int idle, input string where);
        cyc(1, d, where);
        repeat (idle) cyc(0, 8'($urandom), where);
    endtask

    task automatic frame(input logic [7:0] h, input logic [7:0] l, input logic [7:0] flip, input string where);
        send(8'hA5, 0, where);
        send(h, 1, where);
        send(l, 0, where);
        if (FLEN == 4) send(h ^ l ^ flip, 0, where);
        cyc(0, 8'h00, where);
    endtask

    initial begin
        #1;
        check_all("reset");
        @(posedge Clk); #1; nRst = 1;
        frame(8'h12, 8'h34, 8'h00, "basic");
        chk("basic.sample", {16'h0, sample}, 32'h1234);
        send(8'h00, 0, "hunt"); send(8'h7F, 2, "hunt");
        frame(8'hFF, 8'h38, 8'h00, "neg");
        chk("neg.sample", {16'h0, sample}, 32'hFF38);
        send(8'hA5, 0, "tmo"); send(8'h12, 0, "tmo");
        repeat (T + 2) cyc(0, 8'h00, "tmo");
        chk("tmo.cnt", {24'h0, err_count}, 32'd1);
        frame(8'h00, 8'h01, 8'h00, "after_tmo");
        chk("after_tmo.sample", {16'h0, sample}, 32'h0001);
        send(8'hA5, T - 1, "edge"); send(8'hA5, T, "edge");
        send(8'h5A, 0, "edge");
        repeat (T + 1) cyc(0, 8'h00, "edge");
        if (FLEN == 4) begin
            frame(8'h12, 8'h34, 8'h00, "chk_ok");
            frame(8'h12, 8'h34, 8'h01, "chk_bad");
            chk("chk_bad.sample", {16'h0, sample}, 32'h1234);
        end
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0)
                frame(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, "rnd_frame");
            else
                send(($urandom_range(0, 2) == 0) ? 8'hA5 : 8'($urandom),
                     ($urandom_range(0, 7) == 0) ? $urandom_range(T - 2, T + 2) : $urandom_range(0, 3), "rnd_byte");
        end
        for (int i = 0; i < 300; i++) begin
            send(8'hA5, 0, "sat");
            repeat (T) cyc(0, 8'h00, "sat");
        end
        chk("sat.cnt", {24'h0, err_count}, 32'hFF);
        send(8'hA5, 0, "mid"); send(8'h11, 0, "mid");
        rx_ready = 0; nRst = 0; model_reset();
        #1;
        check_all("async_rst");
        @(posedge Clk); #1; nRst = 1;
        frame(8'hAB, 8'hCD, 8'h00, "post_rst");
        chk("post_rst.sample", {16'h0, sample}, 32'hABCD);
        chk("post_rst.cnt", {24'h0, err_count}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
